// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern source: ramps, checker and flat frames.
// Define AXIS_PATGEN_BLANKING_EN to insert H_BLANK idle cycles after each line.
module axis_video_pattern_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int DIM_WIDTH  = 12,
  parameter int H_BLANK    = 16
) (
  input  logic                           i_clk,
  input  logic                           i_areset,
  input  logic                           i_enable,
  input  logic [1:0]                     i_mode,
  input  logic [DIM_WIDTH-1:0]           WIDTH,
  input  logic [DIM_WIDTH-1:0]           HEIGHT,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tuser,
  output logic                           m_axis_tlast,
  output logic                           o_frame_done,
  output logic [15:0]                    o_frame_cnt
);
  localparam int DW = CHANNELS * DATA_WIDTH;

`ifdef AXIS_PATGEN_BLANKING_EN
  localparam int BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;
  logic [BW-1:0] bcnt;
  logic          eof;
`else
  typedef enum logic [1:0] {IDLE, ACTIVE} state_t;
`endif

  state_t               state;
  logic [DIM_WIDTH-1:0] x, y, w, h;
  logic [1:0]           mode;
  logic                 start_ok, x_end, y_end;
  logic [15:0]          cnt_inc;

  assign start_ok = i_enable && (WIDTH != '0) && (HEIGHT != '0);
  assign x_end    = (x == w - 1'b1);
  assign y_end    = (y == h - 1'b1);
  assign cnt_inc  = o_frame_cnt + 16'd1;

  function automatic logic [DW-1:0] pix(
    input logic [1:0]           m,
    input logic [DIM_WIDTH-1:0] px,
    input logic [DIM_WIDTH-1:0] py,
    input logic [15:0]          cnt
  );
    logic [DW-1:0]        d;
    logic [DIM_WIDTH-1:0] t;
    d = '0;
    t = (px ^ py) >> 3;
    for (int c = 0; c < CHANNELS; c++) begin
      case (m)
        2'd0: d[c*DATA_WIDTH +: DATA_WIDTH] =
          DATA_WIDTH'(px) + DATA_WIDTH'(py) + DATA_WIDTH'(c);
        2'd1: d[c*DATA_WIDTH +: DATA_WIDTH] =
          DATA_WIDTH'(px) + DATA_WIDTH'(c);
        2'd2: d[c*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{t[0]}};
        default: d[c*DATA_WIDTH +: DATA_WIDTH] =
          DATA_WIDTH'(cnt) + DATA_WIDTH'(c);
      endcase
    end
    return d;
  endfunction

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      w             <= '0;
      h             <= '0;
      mode          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_cnt   <= '0;
`ifdef AXIS_PATGEN_BLANKING_EN
      bcnt          <= '0;
      eof           <= 1'b0;
`endif
    end else begin
      o_frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            state         <= ACTIVE;
            w             <= WIDTH;
            h             <= HEIGHT;
            mode          <= i_mode;
            x             <= '0;
            y             <= '0;
            m_axis_tvalid <= 1'b1;
            m_axis_tuser  <= 1'b1;
            m_axis_tlast  <= (WIDTH == DIM_WIDTH'(1));
            m_axis_tdata  <= pix(i_mode, '0, '0, o_frame_cnt);
          end
        end
        ACTIVE: begin
          if (m_axis_tready) begin
            m_axis_tuser <= 1'b0;
            if (x_end && y_end) begin
              o_frame_done <= 1'b1;
              o_frame_cnt  <= cnt_inc;
              x            <= '0;
              y            <= '0;
`ifdef AXIS_PATGEN_BLANKING_EN
              if (H_BLANK > 0) begin
                state         <= BLANK;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                bcnt          <= BW'(H_BLANK - 1);
                eof           <= 1'b1;
              end else
`endif
              if (start_ok) begin
                w            <= WIDTH;
                h            <= HEIGHT;
                mode         <= i_mode;
                m_axis_tuser <= 1'b1;
                m_axis_tlast <= (WIDTH == DIM_WIDTH'(1));
                m_axis_tdata <= pix(i_mode, '0, '0, cnt_inc);
              end else begin
                state         <= IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
              end
            end else if (x_end) begin
              x <= '0;
              y <= y + 1'b1;
`ifdef AXIS_PATGEN_BLANKING_EN
              if (H_BLANK > 0) begin
                state         <= BLANK;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                bcnt          <= BW'(H_BLANK - 1);
                eof           <= 1'b0;
              end else
`endif
              begin
                m_axis_tlast <= (w == DIM_WIDTH'(1));
                m_axis_tdata <= pix(mode, '0, y + 1'b1, o_frame_cnt);
              end
            end else begin
              x            <= x + 1'b1;
              m_axis_tlast <= (x + 1'b1 == w - 1'b1);
              m_axis_tdata <= pix(mode, x + 1'b1, y, o_frame_cnt);
            end
          end
        end
`ifdef AXIS_PATGEN_BLANKING_EN
        BLANK: begin
          // x/y already point at the next pixel; eof marks a frame boundary
          if (bcnt != '0) begin
            bcnt <= bcnt - 1'b1;
          end else if (!eof) begin
            state         <= ACTIVE;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (w == DIM_WIDTH'(1));
            m_axis_tdata  <= pix(mode, x, y, o_frame_cnt);
          end else if (start_ok) begin
            state         <= ACTIVE;
            w             <= WIDTH;
            h             <= HEIGHT;
            mode          <= i_mode;
            m_axis_tvalid <= 1'b1;
            m_axis_tuser  <= 1'b1;
            m_axis_tlast  <= (WIDTH == DIM_WIDTH'(1));
            m_axis_tdata  <= pix(i_mode, '0, '0, o_frame_cnt);
          end else begin
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Bench for axis_video_pattern_gen: vector table, hand sequences and
// randomized frames checked against a behavioural frame model.
`timescale 1ns/1ps
module tb_axis_video_pattern_gen;
  localparam int DATA_WIDTH = 8;
  localparam int CHANNELS   = 3;
  localparam int DIM_WIDTH  = 12;
  localparam int H_BLANK    = 3;
  localparam int DW         = DATA_WIDTH * CHANNELS;
`ifdef AXIS_PATGEN_BLANKING_EN
  localparam int HB = H_BLANK;
`else
  localparam int HB = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en  = 1'b0;
  logic                 rdy = 1'b0;
  logic [1:0]           mode = '0;
  logic [DIM_WIDTH-1:0] wd = '0;
  logic [DIM_WIDTH-1:0] ht = '0;
  logic [DW-1:0]        tdata;
  logic                 tvalid, tuser, tlast, done;
  logic [15:0]          fcnt;

  always #5 clk = ~clk;

  axis_video_pattern_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .CHANNELS  (CHANNELS),
    .DIM_WIDTH (DIM_WIDTH),
    .H_BLANK   (H_BLANK)
  ) dut (
    .i_clk        (clk),
    .i_areset     (rst),
    .i_enable     (en),
    .i_mode       (mode),
    .WIDTH        (wd),
    .HEIGHT       (ht),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(rdy),
    .m_axis_tuser (tuser),
    .m_axis_tlast (tlast),
    .o_frame_done (done),
    .o_frame_cnt  (fcnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
  } beat_t;

  typedef struct {
    logic [DATA_WIDTH-1:0] d0;
    logic                  u;
    logic                  l;
  } vec_t;

  beat_t expq[$];
  beat_t got[$];
  vec_t  vt[12];
  int    compared   = 0;
  int    mismatched = 0;
  int    exp_cnt    = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Pattern rules evaluated with plain integer arithmetic
  function automatic logic [DW-1:0] model_pix(int m, int x, int y, int cnt);
    logic [DW-1:0] r;
    int v;
    int full;
    full = 1 << DATA_WIDTH;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (m)
        0: v = x + y + c;
        1: v = x + c;
        2: v = (((x / 8) + (y / 8)) % 2 == 1) ? full - 1 : 0;
        default: v = cnt + c;
      endcase
      r[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(v % full);
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // Runs nf frames, dropping enable during the last one
  task automatic run(input int w, input int h, input int m, input int nf,
                     input int rdy_pct);
    beat_t b, a, prev;
    int total, consumed, done_seen, gaps;
    bit first_seen, prev_stall;
    expq.delete();
    got.delete();
    for (int f = 0; f < nf; f++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          b.d = model_pix(m, x, y, (exp_cnt + f) % 65536);
          b.u = (x == 0 && y == 0);
          b.l = (x == w - 1);
          expq.push_back(b);
        end
    total = expq.size();
    consumed = 0;
    done_seen = 0;
    gaps = 0;
    first_seen = 0;
    prev_stall = 0;
    prev = '{default: '0};
    wd = DIM_WIDTH'(w);
    ht = DIM_WIDTH'(h);
    mode = 2'(m);
    en = 1'b1;
    for (int cyc = 0; cyc < total * 8 + 100 && consumed < total; cyc++) begin
      @(negedge clk);
      rdy = ($urandom_range(99, 0) < rdy_pct);
      if (cyc == 0) check("startup_valid", tvalid, 1);
      if (done) done_seen++;
      a.d = tdata;
      a.u = tuser;
      a.l = tlast;
      if (prev_stall)
        check("stall_hold", {tvalid, a.d, a.u, a.l}, {1'b1, prev.d, prev.u, prev.l});
      if (tvalid) first_seen = 1;
      else if (first_seen) gaps++;
      if (tvalid && rdy) begin
        if (consumed == (nf - 1) * w * h) en = 1'b0;
        b = expq.pop_front();
        check($sformatf("beat%0d", consumed), {a.d, a.u, a.l}, {b.d, b.u, b.l});
        got.push_back(a);
        consumed++;
      end
      prev_stall = tvalid && !rdy;
      prev = a;
    end
    check("beats_done", consumed, total);
    repeat (4 + HB) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    exp_cnt = (exp_cnt + nf) % 65536;
    check("line_gaps", gaps, (nf * h - 1) * HB);
    check("frame_done_cnt", done_seen, nf);
    check("frame_cnt", fcnt, exp_cnt);
    check("idle_after", tvalid, 0);
  endtask

  initial begin
    int dv[12];
    int n;
    dv = '{0, 1, 2, 3, 1, 2, 3, 4, 2, 3, 4, 5};
    for (int i = 0; i < 12; i++) begin
      vt[i].d0 = DATA_WIDTH'(dv[i]);
      vt[i].u  = (i == 0);
      vt[i].l  = (i % 4 == 3);
    end

    repeat (2) @(negedge clk);
    check("reset_outputs", {tvalid, tuser, tlast, done, tdata, fcnt}, 0);
    rst = 1'b0;

    // Zero dimensions never start
    n = 0;
    en = 1'b1; wd = 0; ht = 3;
    repeat (10) begin @(negedge clk); if (tvalid) n++; end
    wd = 3; ht = 0;
    repeat (10) begin @(negedge clk); if (tvalid) n++; end
    en = 1'b0;
    check("zero_dim_valid", n, 0);

    // Basic frame, then the same frame under backpressure
    for (int pass = 0; pass < 2; pass++) begin
      run(4, 3, 0, 1, pass == 0 ? 100 : 50);
      check("basic_len", got.size(), 12);
      if (got.size() == 12)
        for (int i = 0; i < 12; i++)
          check($sformatf("vec%0d_%0d", pass, i),
                {got[i].d[DATA_WIDTH-1:0], got[i].u, got[i].l},
                {vt[i].d0, vt[i].u, vt[i].l});
    end

    run(1, 2, 0, 1, 70);
    run(2, 2, 1, 1, 100);

    run(16, 2, 2, 1, 60);
    if (got.size() == 32) begin
      check("checker_lo", got[7].d, 24'h000000);
      check("checker_hi", got[8].d, 24'hFFFFFF);
    end

    do_reset();
    run(3, 2, 3, 2, 80);
    if (got.size() == 12) begin
      check("flat_f0", got[0].d, 24'h020100);
      check("flat_f1", got[6].d, 24'h030201);
    end

    for (int k = 0; k < 6; k++)
      run($urandom_range(20, 1), $urandom_range(4, 1), $urandom_range(3, 0),
          $urandom_range(3, 1), $urandom_range(100, 30));

    // Reset while beat 5 is on the bus
    do_reset();
    wd = 4; ht = 3; mode = 0; rdy = 1'b1; en = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && n < 5; c++) begin
      @(negedge clk);
      if (tvalid && rdy) n++;
    end
    check("pre_rst_beats", n, 5);
    @(negedge clk);
    check("pre_rst_data", tdata, model_pix(0, 1, 1, 0));
    rst = 1'b1;
    #1;
    check("rst_mid", {tvalid, tuser, tlast, done, tdata, fcnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    check("rst_restart", {tvalid, tuser, tdata, fcnt},
          {1'b1, 1'b1, model_pix(0, 0, 0, 0), 16'd0});
    en = 1'b0;
    n = 0;
    for (int c = 0; c < 200 && tvalid; c++) begin
      if (tvalid && rdy) n++;
      @(negedge clk);
    end
    check("rst_frame_beats", n, 12);
    repeat (HB + 1) @(negedge clk);
    check("rst_frame_cnt", fcnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axis_video_pattern_gen.md
# axis_video_pattern_gen

Synthesizable, parametrised AXI4-Stream video source that replaces the behavioural stream generator in gradient-pipeline benches and serves as an on-chip test-pattern source ahead of the Gx/Gy filter. It emits frames of run-time WIDTH×HEIGHT pixels with tuser on the first pixel and tlast on each line end. It honours m_axis_tready backpressure and packs CHANNELS samples per beat. It supports four selectable patterns and reports frame completion.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per channel sample
- CHANNELS, 1, samples packed per beat (channel c at bits [c*DATA_WIDTH +: DATA_WIDTH])
- DIM_WIDTH, 12, width of WIDTH/HEIGHT ports
- H_BLANK, 16, idle cycles after each line (used only with AXIS_PATGEN_BLANKING_EN)

Ports:
- i_clk  in  1  clock
- i_areset  in  1  asynchronous, active-high reset
- i_enable  in  1  run request; level-sensitive
- i_mode  in  2  pattern select, latched at frame start
- WIDTH  in  DIM_WIDTH  pixels per line, latched at frame start
- HEIGHT  in  DIM_WIDTH  lines per frame, latched at frame start
- m_axis_tdata  out  CHANNELS*DATA_WIDTH  pixel data
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  sink ready
- m_axis_tuser  out  1  start of frame (x=0, y=0)
- m_axis_tlast  out  1  end of line (x=WIDTH-1)
- o_frame_done  out  1  one-cycle pulse on handshake of last frame pixel
- o_frame_cnt  out  16  completed-frame count, wraps 0xFFFF→0

## Operation
- States: IDLE, ACTIVE, BLANK (BLANK exists only with the macro).
- IDLE→ACTIVE: i_enable=1 and latched WIDTH≠0 and HEIGHT≠0. Latch WIDTH, HEIGHT, and i_mode. Reset x and y to 0. Zero dimensions keep the block in IDLE with no output.
- ACTIVE: tvalid=1. x and y advance only on handshake (tvalid & tready). x wraps at WIDTH-1 and increments y.
- tdata, tuser, and tlast are registered. They hold stable while tvalid=1 and tready=0.
- Line end (tlast handshake):
  - With the macro and H_BLANK>0, go to BLANK.
  - Otherwise stay in ACTIVE.
- Frame end (handshake at x=WIDTH-1, y=HEIGHT-1):
  - Pulse o_frame_done.
  - Increment o_frame_cnt.
  - If i_enable=1, relatch the config and restart at (0,0). Otherwise go to IDLE.
- i_enable deasserted mid-frame: the current frame completes. No truncation.
- Patterns for channel c, all results mod 2^DATA_WIDTH:
  - Mode 0, diagonal ramp: x+y+c.
  - Mode 1, horizontal ramp: x+c.
  - Mode 2, checker: all-ones when ((x>>3)^(y>>3))&1 is set, else 0. Identical on all channels.
  - Mode 3, flat: o_frame_cnt[DATA_WIDTH-1:0]+c.
- WIDTH=1: tuser and tlast are set on the same beat. Every beat has tlast.
- Reset (any time, including mid-frame):
  - State IDLE; x, y, and o_frame_cnt are 0.
  - All outputs are 0: tvalid, tdata, tuser, tlast, o_frame_done.
  - A partially sent frame is abandoned.

## Timing
- Startup: i_enable sampled high in IDLE gives tvalid=1 with the (0,0) pixel on the next cycle.
- Throughput: one beat per cycle while tready=1. The next beat is presented the cycle after each handshake.
- Frame-to-frame without blanking: the tuser beat of frame N+1 immediately follows the final beat of frame N.
- o_frame_done is asserted in the cycle after the final handshake, for exactly one cycle. o_frame_cnt updates in the same cycle.
- BLANK: tvalid=0 for exactly H_BLANK cycles after the tlast handshake. Blanking also applies after the last line before the next frame.
- tready must not affect tvalid, so there is no combinational ready→valid path.

## Configuration
- AXIS_PATGEN_BLANKING_EN defined: the BLANK state and its H_BLANK-cycle counter are compiled in. This inserts a horizontal blanking gap after every line.
- Not defined: the BLANK state is absent, the H_BLANK parameter is ignored, and the stream is back-to-back across lines and frames.

## Test plan
- Basic frame: WIDTH=4, HEIGHT=3, mode 0, CHANNELS=1, tready=1 → 12 beats with data 0,1,2,3,1,2,3,4,2,3,4,5. tuser only on beat 0, tlast on beats 3, 7, and 11. One o_frame_done pulse; o_frame_cnt=1.
- Backpressure: same frame, tready toggled pseudo-randomly → identical beat sequence. tdata, tuser, and tlast are held while tready=0, with no lost or duplicated beats.
- Blanking (macro on, H_BLANK=3): WIDTH=2, HEIGHT=2 → tvalid low for exactly 3 cycles after each tlast handshake. Without the macro, 4 consecutive valid cycles.
- Config and enable edges:
  - WIDTH=1, HEIGHT=2 → every beat has tlast; beat 0 has both tuser and tlast.
  - WIDTH=0 → tvalid never asserts.
  - i_enable dropped mid-frame → the frame finishes, then IDLE.
- Patterns and channels: CHANNELS=3, mode 2, WIDTH=16 → tdata switches between 0x000000 and 0xFFFFFF every 8 pixels. In mode 3, the second frame carries 0x030201.
- Reset mid-frame: assert i_areset at beat 5 → all outputs 0 immediately. After release with i_enable=1, the next beat is the (0,0) tuser beat and o_frame_cnt=0.
